// File: rtl/binary_to_bcd_seq_pkg.sv
// ============================================================================
// bcd_pkg : shared types and constants for the sequential binary-to-BCD converter
// Revision 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH  = 4'd5;
  localparam logic [3:0] ADJ_ADD     = 4'd3;
  localparam logic [3:0] BCD_NINE    = 4'h9;

  // Bit counter must be able to hold the value BIN_W itself.
  function automatic int cnt_w(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/binary_to_bcd_seq_if.sv
// ============================================================================
// binary_to_bcd_seq_if : input and output handshakes of the BCD converter
// Revision 1.0
// ============================================================================
`default_nettype none

interface binary_to_bcd_seq_if #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
  logic [DIGITS-1:0]     lead_blank;
  logic                  busy;

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, overflow, lead_blank, busy
  );

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, overflow, lead_blank, busy
  );
endinterface

`default_nettype wire

// File: rtl/binary_to_bcd_seq_digit_adj.sv
// ============================================================================
// bcd_digit_adj : one BCD digit "add 3 if >= 5" correction (4-bit modular)
// Revision 1.0
// ============================================================================
`default_nettype none

module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i + ADJ_ADD) : digit_i;

endmodule

`default_nettype wire

// File: rtl/binary_to_bcd_seq.sv
// ============================================================================
// binary_to_bcd_seq : shift-and-add-3 converter, one bit per clock, with
// overflow saturation and leading-zero blanking. Revision 1.0
// ============================================================================
`default_nettype none

module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  binary_to_bcd_seq_if.slave   bus
);

  localparam int CW = cnt_w(BIN_W);
  localparam int BW = BCD_DIGIT_W * DIGITS;

  if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
    $error("binary_to_bcd_seq: BIN_W must be in 1..32");
  end
  if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
    $error("binary_to_bcd_seq: DIGITS must be in 1..10");
  end

  bcd_state_e          state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [BW-1:0]       out_bcd_q, out_bcd_d;
  logic                out_ovf_q, out_ovf_d;
  logic [DIGITS-1:0]   blank_q, blank_d;

  logic [BW-1:0]       adj_w;
  logic [BW+BIN_W:0]   cat_w;
  logic                ovf_fin_w;
  logic [BW-1:0]       sat_w;
  logic [DIGITS-1:0]   blank_w;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[4*d +: 4]),
      .digit_o (adj_w[4*d +: 4])
    );
  end

  // {carry, bcd, bin} after one left shift; the carry is the overflow bit.
  assign cat_w     = {adj_w, bin_q, 1'b0};
  assign ovf_fin_w = ovf_q | cat_w[BW+BIN_W];
  assign sat_w     = ovf_fin_w ? {DIGITS{BCD_NINE}} : cat_w[BW+BIN_W-1:BIN_W];

  always_comb begin : blank_calc
    logic all_zero;
    all_zero = 1'b1;
    blank_w  = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      all_zero   = all_zero & (sat_w[4*d +: 4] == 4'd0);
      blank_w[d] = all_zero;
    end
    blank_w[0] = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_bcd_d = out_bcd_q;
    out_ovf_d = out_ovf_q;
    blank_d   = blank_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          bin_d   = bus.bin_in;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CW'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bin_d = cat_w[BIN_W-1:0];
        bcd_d = cat_w[BW+BIN_W-1:BIN_W];
        ovf_d = ovf_fin_w;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_bcd_d = sat_w;
          out_ovf_d = ovf_fin_w;
          blank_d   = blank_w;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_bcd_q <= '0;
      out_ovf_q <= 1'b0;
      blank_q   <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_bcd_q <= out_bcd_d;
      out_ovf_q <= out_ovf_d;
      blank_q   <= blank_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.bcd_out    = out_bcd_q;
  assign bus.overflow   = out_ovf_q;
  assign bus.lead_blank = blank_q;

endmodule

`default_nettype wire

// File: tb/tb_binary_to_bcd_seq.sv
// ============================================================================
// tb_binary_to_bcd_seq : directed and random checks of two converter instances
// (4 digits and 3 digits) sharing one stimulus stream. Revision 1.0
// ============================================================================
`default_nettype none

module tb_binary_to_bcd_seq;

  localparam int BIN_W = 10;
  localparam int N_RND = 2000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tb_valid = 1'b0;
  logic tb_ready = 1'b0;
  logic [BIN_W-1:0] tb_bin = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  binary_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(4)) if4 ();
  binary_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(3)) if3 ();

  assign if4.in_valid  = tb_valid;
  assign if4.bin_in    = tb_bin;
  assign if4.out_ready = tb_ready;
  assign if3.in_valid  = tb_valid;
  assign if3.bin_in    = tb_bin;
  assign if3.out_ready = tb_ready;

  binary_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4)
  );

  binary_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: digits by division, saturation and blanking from value.
  function automatic void ref_conv(input int v, input int nd,
                                   output logic [63:0] bcd, output logic ovf,
                                   output logic [63:0] blank);
    longint lim = 1;
    longint pw  = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    ovf   = (v >= lim);
    bcd   = '0;
    blank = '0;
    for (int d = 0; d < nd; d++) begin
      longint dig = ovf ? 9 : (v / pw) % 10;
      bcd = bcd | (64'(dig) << (4 * d));
      if (d > 0 && !ovf && v < pw) blank[d] = 1'b1;
      pw = pw * 10;
    end
  endfunction

  task automatic chk_dut3(input string tag, input int v);
    logic [63:0] eb, ebl;
    logic        eo;
    ref_conv(v, 3, eb, eo, ebl);
    chk({tag, "_d3_valid"}, if3.out_valid, 1);
    chk({tag, "_d3_bcd"},   if3.bcd_out, eb);
    chk({tag, "_d3_ovf"},   if3.overflow, eo);
    chk({tag, "_d3_blank"}, if3.lead_blank, ebl);
  endtask

  // Called at the negedge right after the accepting edge; returns when out_valid seen.
  task automatic wait_result(input string tag, input int v, input logic [15:0] e_bcd,
                             input logic [3:0] e_blank, input logic e_ovf);
    int cnt = 0;
    chk({tag, "_busy"}, if4.busy, 1);
    chk({tag, "_in_ready_busy"}, if4.in_ready, 0);
    while (!if4.out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_latency"}, cnt, BIN_W);
    chk({tag, "_bcd"},   if4.bcd_out, e_bcd);
    chk({tag, "_blank"}, if4.lead_blank, e_blank);
    chk({tag, "_ovf"},   if4.overflow, e_ovf);
    chk_dut3(tag, v);
  endtask

  task automatic convert(input string tag, input int v, input logic [15:0] e_bcd,
                         input logic [3:0] e_blank, input logic e_ovf);
    chk({tag, "_in_ready"}, if4.in_ready, 1);
    tb_bin   = BIN_W'(v);
    tb_valid = 1'b1;
    @(negedge clk);
    tb_valid = 1'b0;
    wait_result(tag, v, e_bcd, e_blank, e_ovf);
  endtask

  task automatic ack(input string tag);
    tb_ready = 1'b1;
    @(negedge clk);
    tb_ready = 1'b0;
    chk({tag, "_ack_valid"}, if4.out_valid, 0);
    chk({tag, "_ack_in_ready"}, if4.in_ready, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] eb, ebl;
    logic        eo;
    int          got, sent, cyc, last_out, last_acc;
    int          exp_q[$];
    int          v;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", if4.out_valid, 0);
    chk("rst_busy", if4.busy, 0);
    chk("rst_bcd", if4.bcd_out, 0);
    chk("rst_ovf", if4.overflow, 0);
    chk("rst_blank", if4.lead_blank, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", if4.in_ready, 1);

    // Zero, maximum and 3-digit limit values
    convert("zero", 0, 16'h0000, 4'b1110, 1'b0);
    ack("zero");
    convert("max", 1023, 16'h1023, 4'b0000, 1'b0);
    ack("max");
    convert("n999", 999, 16'h0999, 4'b1000, 1'b0);
    chk("n999_d3_lit", if3.bcd_out, 12'h999);
    chk("n999_d3_ovf_lit", if3.overflow, 0);
    ack("n999");
    convert("n1000", 1000, 16'h1000, 4'b0000, 1'b0);
    chk("n1000_d3_lit", if3.bcd_out, 12'h999);
    chk("n1000_d3_ovf_lit", if3.overflow, 1);
    ack("n1000");

    // Consumer stalls while a new request is pending
    convert("stall", 999, 16'h0999, 4'b1000, 1'b0);
    tb_bin   = BIN_W'(5);
    tb_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_valid", if4.out_valid, 1);
      chk("stall_bcd", if4.bcd_out, 16'h0999);
      chk("stall_in_ready", if4.in_ready, 0);
    end
    tb_ready = 1'b1;
    @(negedge clk);
    tb_ready = 1'b0;
    chk("release_valid", if4.out_valid, 0);
    chk("release_in_ready", if4.in_ready, 1);
    @(negedge clk);
    tb_valid = 1'b0;
    wait_result("five", 5, 16'h0005, 4'b1110, 1'b0);
    ack("five");

    // Reset during a conversion
    tb_bin   = BIN_W'(512);
    tb_valid = 1'b1;
    @(negedge clk);
    tb_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", if4.out_valid, 0);
    chk("midrst_busy", if4.busy, 0);
    chk("midrst_in_ready", if4.in_ready, 1);
    chk("midrst_bcd", if4.bcd_out, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", if4.in_ready, 1);
    convert("n77", 77, 16'h0077, 4'b1100, 1'b0);
    ack("n77");

    // Back-to-back random stream with both sides always ready
    got = 0; sent = 0; cyc = 0; last_out = -1; last_acc = -1;
    tb_ready = 1'b1;
    tb_valid = 1'b1;
    tb_bin   = BIN_W'($urandom_range(0, 1023));
    while (got < N_RND && cyc < N_RND * (BIN_W + 2) + 200) begin
      logic taken;
      taken = 1'b0;
      if (if4.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_result", 1, 0);
        end else begin
          v = exp_q.pop_front();
          ref_conv(v, 4, eb, eo, ebl);
          chk("rnd_d4_bcd", if4.bcd_out, eb);
          chk("rnd_d4_ovf", if4.overflow, eo);
          chk("rnd_d4_blank", if4.lead_blank, ebl);
          chk_dut3("rnd", v);
        end
        if (last_out >= 0) chk("rnd_out_spacing", cyc - last_out, BIN_W + 2);
        last_out = cyc;
        got++;
      end
      if (if4.in_ready && sent < N_RND) begin
        exp_q.push_back(int'(tb_bin));
        if (last_acc >= 0) chk("rnd_acc_spacing", cyc - last_acc, BIN_W + 2);
        last_acc = cyc;
        sent++;
        taken = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (taken) begin
        if (sent == N_RND) tb_valid = 1'b0;
        else tb_bin = BIN_W'($urandom_range(0, 1023));
      end
    end
    chk("rnd_all_results", got, N_RND);
    tb_ready = 1'b0;
    tb_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
